// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline definitions for the register-file destination path.
// Imported by the scoreboard and its per-register counters.
package reg_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int SB_CNT_W   = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Saturating up/down counter holding the number of in-flight writes to one register.
// Simultaneous inc and dec cancel so an issue and a retire in one cycle leave the count alone.
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             is_zero,
  output logic             is_max
);

  assign is_zero = (count == '0);
  assign is_max  = (count == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && !is_max) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !is_zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts outstanding writes per architectural register between
// decode and write-back and flags source operands whose producer has not retired.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int CNT_W     = SB_CNT_W,
  parameter int BYPASS_WB = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic                    issue_wr,
  input  logic [ADDR_W-1:0]       issue_rd,
  output logic                    issue_ready,
  input  logic                    retire_valid,
  input  logic [ADDR_W-1:0]       retire_rd,
  input  logic [ADDR_W-1:0]       rs_addr,
  input  logic [ADDR_W-1:0]       rt_addr,
  output logic                    rs_busy,
  output logic                    rt_busy,
  output logic                    stall,
  output logic [ADDR_W+CNT_W-1:0] pending_cnt,
  output logic                    underflow_err
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int PEND_W   = ADDR_W + CNT_W;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            cnt_zero;
  logic [NUM_REGS-1:0]            cnt_max;

  logic issue_fire;
  logic retire_fire;
  logic issue_req;
  logic rs_retiring;
  logic rt_retiring;

  // Register 0 has no counter; it looks permanently empty and never saturated.
  assign cnt[0]      = '0;
  assign cnt_zero[0] = 1'b1;
  assign cnt_max[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (issue_fire && (issue_rd == ADDR_W'(r))),
      .dec     (retire_fire && (retire_rd == ADDR_W'(r))),
      .count   (cnt[r]),
      .is_zero (cnt_zero[r]),
      .is_max  (cnt_max[r])
    );
  end

  assign issue_req   = issue_valid && issue_wr;
  assign retire_fire = retire_valid && (retire_rd != REG_ZERO) && !cnt_zero[retire_rd];

  // A saturated destination is still accepted when its own retire frees a slot this cycle.
  assign issue_ready = (issue_valid && !issue_wr) || (issue_rd == REG_ZERO) || !cnt_max[issue_rd]
                       || (retire_fire && (retire_rd == issue_rd));
  assign issue_fire  = issue_req && issue_ready && (issue_rd != REG_ZERO);

  assign rs_retiring = retire_fire && (retire_rd == rs_addr);
  assign rt_retiring = retire_fire && (retire_rd == rt_addr);

  // With write-first bypass, a last pending write retiring now no longer blocks the reader.
  always_comb begin
    rs_busy = !cnt_zero[rs_addr];
    rt_busy = !cnt_zero[rt_addr];
    if (BYPASS_WB != 0) begin
      if (rs_retiring && (cnt[rs_addr] == CNT_W'(1))) rs_busy = 1'b0;
      if (rt_retiring && (cnt[rt_addr] == CNT_W'(1))) rt_busy = 1'b0;
    end
  end

  assign stall = rs_busy || rt_busy || (issue_req && !issue_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_cnt <= '0;
    end else if (issue_fire && !retire_fire) begin
      pending_cnt <= pending_cnt + PEND_W'(1);
    end else if (retire_fire && !issue_fire) begin
      pending_cnt <= pending_cnt - PEND_W'(1);
    end
  end

  // Sticky until reset: write-back retired a register nobody was waiting on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow_err <= 1'b0;
    end else if (retire_valid && (retire_rd != REG_ZERO) && cnt_zero[retire_rd]) begin
      underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized traffic
// compared against a per-register pending-write count model.
module tb_reg_scoreboard;

  localparam int MAXC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_wr, retire_valid;
  logic [4:0] issue_rd, retire_rd, rs_addr, rt_addr;
  logic       issue_ready, rs_busy, rt_busy, stall, underflow_err;
  logic [6:0] pending_cnt;

  int checks = 0;
  int errors = 0;

  int m_cnt[32];
  int m_pending;
  bit m_err;

  reg_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_wr      (issue_wr),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .retire_valid  (retire_valid),
    .retire_rd     (retire_rd),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_busy       (rs_busy),
    .rt_busy       (rt_busy),
    .stall         (stall),
    .pending_cnt   (pending_cnt),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: count of writes outstanding per register.
  function automatic void m_clear();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_pending = 0;
    m_err = 1'b0;
  endfunction

  function automatic bit m_retire_fire();
    return retire_valid && retire_rd != 0 && m_cnt[retire_rd] > 0;
  endfunction

  function automatic bit m_ready();
    if (issue_valid && !issue_wr) return 1'b1;
    if (issue_rd == 0) return 1'b1;
    if (m_cnt[issue_rd] < MAXC) return 1'b1;
    return m_retire_fire() && retire_rd == issue_rd;
  endfunction

  function automatic bit m_busy(input logic [4:0] x);
    int left;
    if (x == 0) return 1'b0;
    left = m_cnt[x];
    if (m_retire_fire() && retire_rd == x) left = left - 1;
    return left > 0;
  endfunction

  function automatic bit m_stall();
    return m_busy(rs_addr) || m_busy(rt_addr) || (issue_valid && issue_wr && !m_ready());
  endfunction

  function automatic void m_commit();
    bit do_issue, do_retire;
    do_issue  = issue_valid && issue_wr && issue_rd != 0 && m_ready();
    do_retire = m_retire_fire();
    if (retire_valid && retire_rd != 0 && m_cnt[retire_rd] == 0) m_err = 1'b1;
    if (do_issue)  begin m_cnt[issue_rd]++;  m_pending++; end
    if (do_retire) begin m_cnt[retire_rd]--; m_pending--; end
  endfunction

  task automatic set_in(input bit iv, input bit iw, input logic [4:0] ird,
                        input bit rv, input logic [4:0] rrd,
                        input logic [4:0] rs, input logic [4:0] rt);
    issue_valid  = iv;
    issue_wr     = iw;
    issue_rd     = ird;
    retire_valid = rv;
    retire_rd    = rrd;
    rs_addr      = rs;
    rt_addr      = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    m_commit();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    m_clear();
    @(posedge clk);
    #2;
    checks++; if (pending_cnt !== 7'd0) begin errors++; $display("[TB] FAIL reset_pending: got %0d expected 0", pending_cnt); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", issue_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", underflow_err); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_issue_busy();
    set_in(1, 1, 5, 0, 0, 5, 0);
    #1;
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_same_cycle: got %b expected 0", rs_busy); end
    tick();
    set_in(0, 0, 0, 0, 0, 5, 0);
    #1;
    checks++; if (rs_busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_next_cycle: got %b expected 1", rs_busy); end
    checks++; if (pending_cnt !== 7'd1) begin errors++; $display("[TB] FAIL busy_pending: got %0d expected 1", pending_cnt); end
    set_in(0, 0, 0, 1, 5, 5, 0);
    #1;
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("[TB] FAIL retire_bypass: got %b expected 0", rs_busy); end
    tick();
    set_in(0, 0, 0, 0, 0, 5, 0);
    #1;
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("[TB] FAIL retire_next: got %b expected 0", rs_busy); end
    checks++; if (pending_cnt !== 7'd0) begin errors++; $display("[TB] FAIL retire_pending: got %0d expected 0", pending_cnt); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 3, 0, 0, 0, 0);
      tick();
    end
    set_in(1, 1, 3, 0, 0, 0, 0);
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL sat_ready: got %b expected 0", issue_ready); end
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL sat_stall: got %b expected 1", stall); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (pending_cnt !== 7'd3) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected 3", pending_cnt); end
    set_in(1, 1, 3, 1, 3, 0, 0);
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL sat_retire_ready: got %b expected 1", issue_ready); end
    tick();
    set_in(0, 0, 0, 0, 0, 3, 0);
    #1;
    checks++; if (pending_cnt !== 7'd3) begin errors++; $display("[TB] FAIL sat_net_zero: got %0d expected 3", pending_cnt); end
    checks++; if (rs_busy !== 1'b1) begin errors++; $display("[TB] FAIL sat_busy: got %b expected 1", rs_busy); end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 1, 3, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (pending_cnt !== 7'd0) begin errors++; $display("[TB] FAIL sat_drain: got %0d expected 0", pending_cnt); end
  endtask

  task automatic test_same_cycle();
    set_in(1, 1, 7, 0, 0, 0, 7);
    tick();
    set_in(1, 1, 7, 1, 7, 0, 7);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 7);
    #1;
    checks++; if (rt_busy !== 1'b1) begin errors++; $display("[TB] FAIL same_rt_busy: got %b expected 1", rt_busy); end
    checks++; if (pending_cnt !== 7'd1) begin errors++; $display("[TB] FAIL same_pending: got %0d expected 1", pending_cnt); end
    set_in(0, 0, 0, 1, 7, 0, 0);
    tick();
  endtask

  task automatic test_reg_zero();
    set_in(1, 1, 0, 0, 0, 0, 0);
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL r0_ready: got %b expected 1", issue_ready); end
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("[TB] FAIL r0_busy: got %b expected 0", rs_busy); end
    tick();
    set_in(0, 0, 0, 1, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (pending_cnt !== 7'd0) begin errors++; $display("[TB] FAIL r0_pending: got %0d expected 0", pending_cnt); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("[TB] FAIL r0_err: got %b expected 0", underflow_err); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0, 5'($urandom_range(0, 4)),
             $urandom_range(0, 2) == 0, 5'($urandom_range(0, 4)),
             5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)));
      #1;
      checks++; if (issue_ready !== m_ready()) begin errors++; $display("[TB] FAIL rnd_ready@%0d: got %b expected %b", n, issue_ready, m_ready()); end
      checks++; if (rs_busy !== m_busy(rs_addr)) begin errors++; $display("[TB] FAIL rnd_rs_busy@%0d: got %b expected %b", n, rs_busy, m_busy(rs_addr)); end
      checks++; if (rt_busy !== m_busy(rt_addr)) begin errors++; $display("[TB] FAIL rnd_rt_busy@%0d: got %b expected %b", n, rt_busy, m_busy(rt_addr)); end
      checks++; if (stall !== m_stall()) begin errors++; $display("[TB] FAIL rnd_stall@%0d: got %b expected %b", n, stall, m_stall()); end
      checks++; if (int'(pending_cnt) != m_pending) begin errors++; $display("[TB] FAIL rnd_pending@%0d: got %0d expected %0d", n, pending_cnt, m_pending); end
      checks++; if (underflow_err !== m_err) begin errors++; $display("[TB] FAIL rnd_err@%0d: got %b expected %b", n, underflow_err, m_err); end
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    set_in(1, 1, 8, 0, 0, 8, 0);
    tick();
    tick();
    set_in(1, 1, 8, 0, 0, 8, 0);
    #1;
    checks++; if (rs_busy !== m_busy(5'd8)) begin errors++; $display("[TB] FAIL mid_busy_before: got %b expected %b", rs_busy, m_busy(5'd8)); end
    reset = 1'b1;
    m_clear();
    #1;
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", rs_busy); end
    checks++; if (pending_cnt !== 7'd0) begin errors++; $display("[TB] FAIL mid_pending: got %0d expected 0", pending_cnt); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready: got %b expected 1", issue_ready); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_err: got %b expected 0", underflow_err); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_underflow();
    set_in(0, 0, 0, 1, 9, 0, 0);
    #1;
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("[TB] FAIL uf_same_cycle: got %b expected 0", underflow_err); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("[TB] FAIL uf_set: got %b expected 1", underflow_err); end
    checks++; if (pending_cnt !== 7'd0) begin errors++; $display("[TB] FAIL uf_pending: got %0d expected 0", pending_cnt); end
    set_in(1, 1, 2, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 1, 2, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("[TB] FAIL uf_sticky: got %b expected 1", underflow_err); end
  endtask

  initial begin
    test_reset();
    test_issue_busy();
    test_saturation();
    test_same_cycle();
    test_reg_zero();
    test_random();
    test_reset_mid_run();
    test_underflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
